// File: rtl/mux5_pkg.sv
// ============================================================================
// Module   : mux5_pkg
// Brief    : Shared select codes, FSM state type and round-robin search helper
//            for the five-source byte arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux5_pkg;

  localparam logic [2:0] SEL_IDLE = 3'd0;
  localparam logic [2:0] SEL_A    = 3'd1;
  localparam logic [2:0] SEL_B    = 3'd2;
  localparam logic [2:0] SEL_C    = 3'd3;
  localparam logic [2:0] SEL_D    = 3'd4;
  localparam logic [2:0] SEL_E    = 3'd5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Returns {found, idx}; the search starts one past 'last' and wraps mod 5.
  function automatic logic [3:0] next_rr(input logic [4:0] req,
                                         input logic [2:0] last);
    logic [3:0] result;
    logic [2:0] idx;
    int         t;
    result = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      t = int'(last) + k;
      if (t >= 5) t = t - 5;
      idx = 3'(t);
      if (!result[3] && req[idx]) result = {1'b1, idx};
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux5_byte_sel.sv
// ============================================================================
// Module   : mux5_byte_sel
// Brief    : Combinational 5-to-1 byte mux with one-hot grant decode; codes
//            0, 6 and 7 give zero data and no grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux5_byte_sel
  import mux5_pkg::*;
(
  input  logic [2:0] sel_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [7:0] c_i,
  input  logic [7:0] d_i,
  input  logic [7:0] e_i,
  output logic [7:0] data_o,
  output logic [4:0] gnt_o
);

  always_comb begin
    data_o = 8'h00;
    gnt_o  = 5'b00000;
    case (sel_i)
      SEL_A: begin data_o = a_i; gnt_o = 5'b00001; end
      SEL_B: begin data_o = b_i; gnt_o = 5'b00010; end
      SEL_C: begin data_o = c_i; gnt_o = 5'b00100; end
      SEL_D: begin data_o = d_i; gnt_o = 5'b01000; end
      SEL_E: begin data_o = e_i; gnt_o = 5'b10000; end
      default: begin data_o = 8'h00; gnt_o = 5'b00000; end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mux5_rr_arbiter.sv
// ============================================================================
// Module   : mux5_rr_arbiter
// Brief    : Round-robin arbiter with bounded bursts sharing one byte channel
//            among five sources, valid/ready handshake downstream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux5_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] d,
  input  logic [7:0] e,
  output logic [2:0] sel,
  output logic [4:0] gnt,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);
  import mux5_pkg::*;

  localparam logic [3:0] C_HOLD_LAST = 4'(HOLD_MAX - 1);

  state_t     state_q;
  logic [2:0] sel_q;
  logic [2:0] last_q;
  logic [3:0] cnt_q;

  logic [4:0] w_gnt;
  logic [7:0] w_data;
  logic [3:0] w_rr;
  logic       w_req_cur;
  logic       w_xfer;
  logic       w_release;

  mux5_byte_sel u_byte_sel (
    .sel_i  (sel_q),
    .a_i    (a),
    .b_i    (b),
    .c_i    (c),
    .d_i    (d),
    .e_i    (e),
    .data_o (w_data),
    .gnt_o  (w_gnt)
  );

  // Searching from last+1 already leaves the releasing source at the back of
  // the order, so it only wins again when it is the sole requester.
  assign w_rr      = next_rr(req, last_q);
  assign w_req_cur = |(w_gnt & req);
  assign w_xfer    = out_valid && out_ready;
  assign w_release = !w_req_cur || (w_xfer && (cnt_q == C_HOLD_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= SEL_IDLE;
      last_q  <= 3'd4;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_rr[3]) begin
            state_q <= GRANT;
            sel_q   <= w_rr[2:0] + 3'd1;
            last_q  <= w_rr[2:0];
            cnt_q   <= 4'd0;
          end
        end
        GRANT: begin
          if (w_release) begin
            cnt_q <= 4'd0;
            if (w_rr[3]) begin
              sel_q  <= w_rr[2:0] + 3'd1;
              last_q <= w_rr[2:0];
            end else begin
              state_q <= IDLE;
              sel_q   <= SEL_IDLE;
            end
          end else if (w_xfer) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= SEL_IDLE;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign gnt       = w_gnt;
  assign out_data  = w_data;
  assign busy      = (state_q == GRANT);
  assign out_valid = busy && w_req_cur;

endmodule

`default_nettype wire

// File: tb/tb_mux5_rr_arbiter.sv
// ============================================================================
// Module   : tb_mux5_rr_arbiter
// Brief    : Directed self-checking bench for the five-source byte arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux5_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [4:0] req;
  logic [7:0] a, b, c, d, e;
  logic [2:0] sel;
  logic [4:0] gnt;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int total;
  int bad;

  mux5_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .sel       (sel),
    .gnt       (gnt),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held across one edge, released just after an edge with new req.
  task automatic do_reset(input logic [4:0] r, input logic rdy);
    rst = 1'b1;
    tick();
    req       = r;
    out_ready = rdy;
    rst       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 5'b11111;
    out_ready = 1'b1;
    #3;
    total++;
    if (sel !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    total++;
    if (gnt !== 5'b00000) begin bad++; $display("FAIL reset_gnt got=%b exp=00000", gnt); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++;
    if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (sel !== 3'd1) begin bad++; $display("FAIL first_sel got=%0d exp=1", sel); end
    total++;
    if (gnt !== 5'b00001) begin bad++; $display("FAIL first_gnt got=%b exp=00001", gnt); end
    total++;
    if (out_data !== 8'h11) begin bad++; $display("FAIL first_data got=%h exp=11", out_data); end
  endtask

  task automatic test_idle();
    do_reset(5'b00000, 1'b1);
    tick();
    tick();
    total++;
    if (sel !== 3'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_hold sel=%0d busy=%b exp sel=0 busy=0", sel, busy);
    end
    req = 5'b00100;
    tick();
    total++;
    if (sel !== 3'd3 || gnt !== 5'b00100) begin
      bad++; $display("FAIL idle_to_c sel=%0d gnt=%b exp sel=3 gnt=00100", sel, gnt);
    end
  endtask

  task automatic test_rotation();
    logic [2:0] exp_sel [3];
    logic [7:0] exp_dat [3];
    int         k;
    exp_sel[0] = 3'd1; exp_sel[1] = 3'd3; exp_sel[2] = 3'd5;
    exp_dat[0] = 8'h11; exp_dat[1] = 8'h33; exp_dat[2] = 8'h55;
    do_reset(5'b10101, 1'b1);
    tick();
    for (int i = 0; i < 13; i++) begin
      k = (i / 4) % 3;
      total++;
      if (sel !== exp_sel[k] || out_data !== exp_dat[k] || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL rotation[%0d] sel=%0d data=%h valid=%b exp sel=%0d data=%h valid=1",
                 i, sel, out_data, out_valid, exp_sel[k], exp_dat[k]);
      end
      tick();
    end
  endtask

  task automatic test_early_drop();
    do_reset(5'b01010, 1'b1);
    tick();
    total++;
    if (sel !== 3'd2) begin bad++; $display("FAIL drop_grant_b got=%0d exp=2", sel); end
    tick();
    tick();
    req = 5'b01001;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL drop_valid valid=%b busy=%b exp valid=0 busy=1", out_valid, busy);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (sel !== 3'd4 || out_data !== 8'h44 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL drop_d[%0d] sel=%0d data=%h valid=%b exp sel=4 data=44 valid=1",
                 i, sel, out_data, out_valid);
      end
      tick();
    end
    total++;
    if (sel !== 3'd1) begin bad++; $display("FAIL drop_next_a got=%0d exp=1", sel); end
  endtask

  task automatic test_backpressure();
    do_reset(5'b01000, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (sel !== 3'd4 || out_data !== 8'h44 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall[%0d] sel=%0d data=%h valid=%b exp sel=4 data=44 valid=1",
                 i, sel, out_data, out_valid);
      end
      tick();
    end
    out_ready = 1'b1;
    req = 5'b01001;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (sel !== 3'd4) begin bad++; $display("FAIL stall_xfer[%0d] got=%0d exp=4", i, sel); end
      tick();
    end
    total++;
    if (sel !== 3'd1) begin bad++; $display("FAIL stall_release got=%0d exp=1", sel); end
  endtask

  task automatic test_single();
    do_reset(5'b00010, 1'b1);
    tick();
    for (int i = 0; i < 12; i++) begin
      total++;
      if (sel !== 3'd2 || out_valid !== 1'b1 || out_data !== 8'h22) begin
        bad++;
        $display("FAIL single[%0d] sel=%0d valid=%b data=%h exp sel=2 valid=1 data=22",
                 i, sel, out_valid, out_data);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset(5'b10000, 1'b1);
    tick();
    total++;
    if (sel !== 3'd5) begin bad++; $display("FAIL ar_grant_e got=%0d exp=5", sel); end
    tick();
    #2;
    rst = 1'b1;
    req = 5'b10011;
    #1;
    total++;
    if (sel !== 3'd0 || gnt !== 5'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ar_outputs sel=%0d gnt=%b valid=%b data=%h busy=%b exp all zero",
               sel, gnt, out_valid, out_data, busy);
    end
    #1;
    rst = 1'b0;
    tick();
    total++;
    if (sel !== 3'd1 || gnt !== 5'b00001) begin
      bad++; $display("FAIL ar_a_first sel=%0d gnt=%b exp sel=1 gnt=00001", sel, gnt);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 5'b0;
    out_ready = 1'b0;
    a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44; e = 8'h55;
    test_reset();
    test_idle();
    test_rotation();
    test_early_drop();
    test_backpressure();
    test_single();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux5_rr_arbiter.md
# mux5_rr_arbiter

Round-robin arbiter that shares one 8-bit output channel among five byte-wide requesters. It drives the 3-bit select code of the five-way byte multiplexer, holds each grant for a bounded burst, and presents the selected byte to a downstream consumer with a valid/ready handshake. It sits between the five source blocks and the shared byte sink.

## Interface
- HOLD_MAX, default 4: maximum accepted transfers per grant, 1..15.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  5  request per source; bit 0 is source A, bit 4 is source E.
- a, b, c, d, e  in  8 each  source data bytes.
- sel  out  3  mux select code: 3'd0 idle; 3'd1..3'd5 select a..e.
- gnt  out  5  one-hot grant matching sel; all zero when idle.
- out_data  out  8  selected byte; 8'h00 when sel is 0 or 3'd6/3'd7.
- out_valid  out  1  byte on out_data is offered downstream.
- out_ready  in  1  downstream accepts the byte this cycle.
- busy  out  1  high while in GRANT.

## Operation
- Two-state FSM: IDLE, GRANT. Registers: state, sel, last (source index 0..4 of the most recent grant), cnt (4 bits, transfers in the current grant).
- Reset: state=IDLE, sel=0, gnt=0, last=4 (source A has first priority), cnt=0, out_valid=0, out_data=8'h00, busy=0.
- Arbitration: search order starts at last+1 and wraps modulo 5 (last=4 -> 0,1,2,3,4). The first set req bit wins. Arbitration runs at an edge when state=IDLE, or when the current grant releases.
- IDLE: if any req is set, go to GRANT with sel=winner+1, last=winner, cnt=0. Otherwise stay.
- Transfer: out_valid && out_ready at the edge. cnt increments.
- GRANT release conditions, evaluated at each edge:
  - req of the granted source is low, or
  - a transfer occurs with cnt==HOLD_MAX-1.
- On release, arbitrate among the current req bits, excluding the releasing source only if another requester is set. If there is a winner, reload sel, last and cnt in the same edge with no idle cycle. If there is none, go to IDLE with sel=0.
- A source that is the only requester is re-granted back to back after HOLD_MAX transfers.
- Outputs:
  - out_valid = (state==GRANT) && req[sel-1].
  - out_data = the byte selected by sel (combinational from the registered sel).
  - gnt = decode of sel.
  - busy = (state==GRANT).
- out_ready low stalls: cnt holds and the grant holds for as long as req stays high.
- sel never takes 3'd6 or 3'd7. The decoder still maps them to 8'h00 and gnt=0.

## Timing
- Request-to-grant latency: 1 cycle. req rises before edge N, so sel and gnt are valid after edge N.
- Data path from a..e to out_data is combinational through the mux. No added latency.
- Back-to-back handover: the last transfer of source i at edge N gives sel = new source after edge N. There are no bubbles.
- Dropping req mid-grant: release takes effect at the next edge. out_valid falls in the same cycle as req, because it is gated combinationally.
- Reset asserted mid-burst: all outputs immediately return to their reset values, with no dependency on clk. Any in-flight transfer is abandoned. After deassertion, source A has first priority.
- req changes on non-granted sources never disturb the current grant.

## Structure
- Shared package mux5_pkg:
  - SEL_IDLE=3'd0, SEL_A..SEL_E=3'd1..3'd5.
  - State enum {IDLE, GRANT}.
  - Function next_rr(req, last) returning {found, idx}.
- Sub-module mux5_byte_sel: purely combinational 5-to-1 byte mux with sel decoding and a full default (0). It is instantiated once.
- Top module: FSM, round-robin pointer, burst counter and handshake gating.

## Test plan
- Reset and idle:
  - Assert rst with req=5'b11111 -> sel=0, gnt=0, out_valid=0, out_data=8'h00.
  - Release rst -> after 1 edge, sel=3'd1 and gnt=5'b00001.
- Rotation:
  - req=5'b10101, out_ready=1, HOLD_MAX=4, a=8'h11, c=8'h33, e=8'h55.
  - Required: 4 transfers of 8'h11, then 4 of 8'h33, then 4 of 8'h55, then A again, with no idle cycles.
- Early drop:
  - Source B is granted and drops req after 2 transfers while req[3] is set.
  - Required: out_valid falls that cycle, the next edge gives sel=3'd4, and cnt restarts.
- Backpressure:
  - Source D is granted and out_ready is held low for 6 cycles.
  - Required: sel stays 3'd4, out_data=d, out_valid=1, and no count advance. Then 4 transfers occur before release.
- Single requester: only req[1] is set -> continuous grant of B, with cnt wrapping every HOLD_MAX transfers and sel never returning to 0.
- Async reset mid-burst:
  - Assert rst between clock edges during a grant of E.
  - Required: outputs reach their reset values before the next edge, and the first grant after reset follows A-first priority.
